// File: rtl/gpio_pkg.sv
// Register map and address-split helpers shared by the GPIO bank and its
// per-port synchroniser.
package gpio_pkg;

  localparam int REG_BITS  = 3;
  localparam int DATA_BITS = 8;

  localparam logic [2:0] REG_ODR = 3'd0;
  localparam logic [2:0] REG_DDR = 3'd1;
  localparam logic [2:0] REG_IDR = 3'd2;
  localparam logic [2:0] REG_REN = 3'd3;
  localparam logic [2:0] REG_FEN = 3'd4;
  localparam logic [2:0] REG_IFR = 3'd5;
  localparam logic [2:0] REG_ODE = 3'd6;
  localparam logic [2:0] REG_RSV = 3'd7;

  // Width of the port-index field above the register offset.
  function automatic int port_bits(input int nports);
    return $clog2(nports);
  endfunction

  // Total register address width for a bank of nports ports.
  function automatic int addr_bits(input int nports);
    return port_bits(nports) + REG_BITS;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Pad input synchroniser with rise/fall detection on the last stage versus
// a one-cycle-delayed copy of it.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [STAGES-1:0][WIDTH-1:0] stage_r;
  logic [WIDTH-1:0]             prev_r;

  // Synchroniser chain plus the delayed copy used for edge comparison.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_r <= {(STAGES*WIDTH){1'b0}};
      prev_r  <= {WIDTH{1'b0}};
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
      prev_r <= stage_r[STAGES-1];
    end
  end

  assign sync = stage_r[STAGES-1];
  assign rise = stage_r[STAGES-1] & ~prev_r;
  assign fall = ~stage_r[STAGES-1] & prev_r;

endmodule

// File: rtl/gpio_bank.sv
// Multi-port GPIO bank: per-port output/direction/open-drain control,
// synchronised inputs and edge-triggered interrupt flags.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int NPORTS      = 3,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      power_on_reset_n,
  input  logic [$clog2(NPORTS)+2:0] addr,
  input  logic [7:0]                dwrite,
  input  logic                      write_en,
  input  logic                      read_en,
  output logic [7:0]                dread,
  input  logic [NPORTS*WIDTH-1:0]   pins_i,
  output logic [NPORTS*WIDTH-1:0]   pins_o,
  output logic [NPORTS*WIDTH-1:0]   pins_oe,
  output logic                      irq
);

  localparam int AW = addr_bits(NPORTS);
  localparam int NW = NPORTS * WIDTH;
  localparam logic [AW-1:0] NPORTS_A = AW'(NPORTS);
  localparam logic [2:0]    BLANK_L  = 3'(SYNC_STAGES + 1);

  logic [NPORTS-1:0][WIDTH-1:0] odr_r, ddr_r, ren_r, fen_r, ifr_r, ode_r;
  logic [NPORTS-1:0][WIDTH-1:0] odr_n, ddr_n, ren_n, fen_n, ifr_n, ode_n;
  logic [NPORTS-1:0][WIDTH-1:0] idr_s, rise_s, fall_s;

  logic [AW-1:0]  port_s;
  logic [2:0]     reg_s;
  logic           port_ok_s;
  logic [7:0]     rdata_s;
  logic [7:0]     dread_r;
  logic           irq_r;
  logic [NW-1:0]  pins_o_r, pins_oe_r, pins_o_n, pins_oe_n;
  logic [2:0]     blank_r;
  logic           armed_s;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    gpio_sync #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .rst_n (power_on_reset_n),
      .din   (pins_i[p*WIDTH +: WIDTH]),
      .sync  (idr_s[p]),
      .rise  (rise_s[p]),
      .fall  (fall_s[p])
    );
  end

  assign port_s    = addr >> REG_BITS;
  assign reg_s     = addr[2:0];
  assign port_ok_s = (port_s < NPORTS_A);

  // Edges are ignored until the synchroniser has refilled after reset,
  // so pads already high at release do not raise flags.
  assign armed_s = (blank_r == BLANK_L);

  // Post-reset blanking counter, saturating once the window has elapsed.
  always_ff @(posedge clk) begin
    if (!power_on_reset_n) begin
      blank_r <= 3'd0;
    end else if (blank_r != BLANK_L) begin
      blank_r <= blank_r + 3'd1;
    end else begin
      blank_r <= blank_r;
    end
  end

  // Next-state for the control registers; edge set is applied after the
  // write-1-to-clear so that a simultaneous set wins.
  always_comb begin
    odr_n = odr_r;
    ddr_n = ddr_r;
    ren_n = ren_r;
    fen_n = fen_r;
    ifr_n = ifr_r;
    ode_n = ode_r;
    for (int p = 0; p < NPORTS; p++) begin
      if (write_en && port_ok_s && (port_s == AW'(p))) begin
        case (reg_s)
          REG_ODR: odr_n[p] = dwrite[WIDTH-1:0];
          REG_DDR: ddr_n[p] = dwrite[WIDTH-1:0];
          REG_REN: ren_n[p] = dwrite[WIDTH-1:0];
          REG_FEN: fen_n[p] = dwrite[WIDTH-1:0];
          REG_IFR: ifr_n[p] = ifr_r[p] & ~dwrite[WIDTH-1:0];
          REG_ODE: ode_n[p] = dwrite[WIDTH-1:0];
          default: odr_n[p] = odr_r[p];
        endcase
      end else begin
        ifr_n[p] = ifr_r[p];
      end
      if (armed_s) begin
        ifr_n[p] = ifr_n[p] | (rise_s[p] & ren_r[p]) | (fall_s[p] & fen_r[p]);
      end else begin
        ifr_n[p] = ifr_n[p];
      end
    end
  end

  // Pad drive computed from next-state so the registered pads follow a
  // write in the very next cycle.
  always_comb begin
    pins_o_n  = {NW{1'b0}};
    pins_oe_n = {NW{1'b0}};
    for (int p = 0; p < NPORTS; p++) begin
      pins_o_n[p*WIDTH +: WIDTH]  = odr_n[p] & ~ode_n[p];
      pins_oe_n[p*WIDTH +: WIDTH] = ddr_n[p] & ~(ode_n[p] & odr_n[p]);
    end
  end

  // Read mux; unmapped ports and the reserved offset return zero.
  always_comb begin
    rdata_s = 8'h00;
    for (int p = 0; p < NPORTS; p++) begin
      if (port_ok_s && (port_s == AW'(p))) begin
        case (reg_s)
          REG_ODR: rdata_s[WIDTH-1:0] = odr_r[p];
          REG_DDR: rdata_s[WIDTH-1:0] = ddr_r[p];
          REG_IDR: rdata_s[WIDTH-1:0] = idr_s[p];
          REG_REN: rdata_s[WIDTH-1:0] = ren_r[p];
          REG_FEN: rdata_s[WIDTH-1:0] = fen_r[p];
          REG_IFR: rdata_s[WIDTH-1:0] = ifr_r[p];
          REG_ODE: rdata_s[WIDTH-1:0] = ode_r[p];
          default: rdata_s = 8'h00;
        endcase
      end else begin
        rdata_s = rdata_s;
      end
    end
  end

  // Architectural state, registered outputs and read data.
  always_ff @(posedge clk) begin
    if (!power_on_reset_n) begin
      odr_r     <= {NW{1'b0}};
      ddr_r     <= {NW{1'b0}};
      ren_r     <= {NW{1'b0}};
      fen_r     <= {NW{1'b0}};
      ifr_r     <= {NW{1'b0}};
      ode_r     <= {NW{1'b0}};
      pins_o_r  <= {NW{1'b0}};
      pins_oe_r <= {NW{1'b0}};
      dread_r   <= 8'h00;
      irq_r     <= 1'b0;
    end else begin
      odr_r     <= odr_n;
      ddr_r     <= ddr_n;
      ren_r     <= ren_n;
      fen_r     <= fen_n;
      ifr_r     <= ifr_n;
      ode_r     <= ode_n;
      pins_o_r  <= pins_o_n;
      pins_oe_r <= pins_oe_n;
      irq_r     <= |(ifr_r & (ren_r | fen_r));
      if (read_en) begin
        dread_r <= rdata_s;
      end else begin
        dread_r <= dread_r;
      end
    end
  end

  assign dread   = dread_r;
  assign irq     = irq_r;
  assign pins_o  = pins_o_r;
  assign pins_oe = pins_oe_r;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank (3 ports x 8 pins, 2 sync stages).
module tb_gpio_bank;

  localparam int NPORTS      = 3;
  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;

  logic        clk;
  logic        power_on_reset_n;
  logic [4:0]  addr;
  logic [7:0]  dwrite;
  logic        write_en;
  logic        read_en;
  logic [7:0]  dread;
  logic [23:0] pins_i;
  logic [23:0] pins_o;
  logic [23:0] pins_oe;
  logic        irq;

  int total;
  int bad;

  gpio_bank #(
    .NPORTS      (NPORTS),
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk              (clk),
    .power_on_reset_n (power_on_reset_n),
    .addr             (addr),
    .dwrite           (dwrite),
    .write_en         (write_en),
    .read_en          (read_en),
    .dread            (dread),
    .pins_i           (pins_i),
    .pins_o           (pins_o),
    .pins_oe          (pins_oe),
    .irq              (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] ra(input int p, input int r);
    return 5'(p * 8 + r);
  endfunction

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    addr = a; dwrite = d; write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, output logic [7:0] d);
    addr = a; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    d = dread;
  endtask

  task automatic test_reset();
    logic [7:0] d, exp;
    logic [23:0] pv;
    power_on_reset_n = 1'b0;
    pins_i = 24'h3C5A81;
    repeat (3) tick();
    total++; if (dread !== 8'h00) begin bad++; $display("FAIL reset_dread got=%h exp=00", dread); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++; if (pins_oe !== 24'h0) begin bad++; $display("FAIL reset_oe got=%h exp=000000", pins_oe); end
    total++; if (pins_o !== 24'h0) begin bad++; $display("FAIL reset_o got=%h exp=000000", pins_o); end
    power_on_reset_n = 1'b1;
    repeat (4) tick();
    pv = pins_i;
    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r < 8; r++) begin
        exp = (r == 2 && p < 3) ? pv[p*8 +: 8] : 8'h00;
        do_read(ra(p, r), d);
        total++;
        if (d !== exp) begin bad++; $display("FAIL reset_map p=%0d r=%0d got=%h exp=%h", p, r, d, exp); end
      end
    end
    total++; if (pins_oe !== 24'h0) begin bad++; $display("FAIL post_reset_oe got=%h exp=000000", pins_oe); end
  endtask

  task automatic test_push_pull();
    logic [7:0] d;
    do_write(ra(1, 1), 8'hFF);
    total++; if (pins_oe[15:8] !== 8'hFF) begin bad++; $display("FAIL pp_oe_ddr got=%h exp=ff", pins_oe[15:8]); end
    total++; if (pins_o[15:8] !== 8'h00) begin bad++; $display("FAIL pp_o_ddr got=%h exp=00", pins_o[15:8]); end
    do_write(ra(1, 0), 8'hA5);
    total++; if (pins_o[15:8] !== 8'hA5) begin bad++; $display("FAIL pp_o got=%h exp=a5", pins_o[15:8]); end
    total++; if (pins_oe[15:8] !== 8'hFF) begin bad++; $display("FAIL pp_oe got=%h exp=ff", pins_oe[15:8]); end
    total++; if (pins_oe[7:0] !== 8'h00) begin bad++; $display("FAIL pp_oe_p0 got=%h exp=00", pins_oe[7:0]); end
    addr = ra(1, 0); dwrite = 8'h5A; write_en = 1'b1; read_en = 1'b1;
    tick();
    write_en = 1'b0; read_en = 1'b0;
    total++; if (dread !== 8'hA5) begin bad++; $display("FAIL rw_same_old got=%h exp=a5", dread); end
    total++; if (pins_o[15:8] !== 8'h5A) begin bad++; $display("FAIL rw_same_pins got=%h exp=5a", pins_o[15:8]); end
    tick();
    total++; if (dread !== 8'hA5) begin bad++; $display("FAIL dread_hold got=%h exp=a5", dread); end
    do_read(ra(1, 0), d);
    total++; if (d !== 8'h5A) begin bad++; $display("FAIL rw_same_new got=%h exp=5a", d); end
  endtask

  task automatic test_open_drain();
    do_write(ra(0, 6), 8'h0F);
    do_write(ra(0, 1), 8'hFF);
    do_write(ra(0, 0), 8'h05);
    total++; if (pins_oe[3:0] !== 4'hA) begin bad++; $display("FAIL od_oe_lo got=%h exp=a", pins_oe[3:0]); end
    total++; if (pins_o[3:0] !== 4'h0) begin bad++; $display("FAIL od_o_lo got=%h exp=0", pins_o[3:0]); end
    total++; if (pins_oe[7:0] !== 8'hFA) begin bad++; $display("FAIL od_oe_byte got=%h exp=fa", pins_oe[7:0]); end
    do_write(ra(0, 0), 8'hF5);
    total++; if (pins_o[7:0] !== 8'hF0) begin bad++; $display("FAIL od_o_mixed got=%h exp=f0", pins_o[7:0]); end
    total++; if (pins_oe[7:0] !== 8'hFA) begin bad++; $display("FAIL od_oe_mixed got=%h exp=fa", pins_oe[7:0]); end
  endtask

  task automatic test_unmapped();
    logic [7:0] d;
    do_write(5'd24, 8'hFF);
    do_read(5'd24, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL unmapped_port got=%h exp=00", d); end
    do_read(ra(0, 0), d);
    total++; if (d !== 8'hF5) begin bad++; $display("FAIL no_alias got=%h exp=f5", d); end
    do_write(ra(0, 7), 8'hFF);
    do_read(ra(0, 7), d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL reserved got=%h exp=00", d); end
    do_write(ra(1, 2), 8'hFF);
    do_read(ra(1, 2), d);
    total++; if (d !== 8'h5A) begin bad++; $display("FAIL idr_ro got=%h exp=5a", d); end
  endtask

  task automatic test_rise_irq();
    logic [7:0] d;
    do_write(ra(2, 3), 8'h01);
    pins_i[16] = 1'b1;
    tick();
    tick();
    addr = ra(2, 5); read_en = 1'b1;
    tick();
    total++; if (dread !== 8'h00) begin bad++; $display("FAIL rise_early got=%h exp=00", dread); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rise_irq_early got=%b exp=0", irq); end
    tick();
    read_en = 1'b0;
    total++; if (dread !== 8'h01) begin bad++; $display("FAIL rise_flag got=%h exp=01", dread); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL rise_irq got=%b exp=1", irq); end
    do_write(ra(2, 5), 8'h00);
    do_read(ra(2, 5), d);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL w0_noclear got=%h exp=01", d); end
    do_write(ra(2, 5), 8'h01);
    tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL clear_irq got=%b exp=0", irq); end
    do_read(ra(2, 5), d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL clear_flag got=%h exp=00", d); end
  endtask

  task automatic test_set_clear_collision();
    logic [7:0] d;
    do_write(ra(0, 4), 8'h80);
    pins_i[7] = 1'b0;
    tick();
    tick();
    do_write(ra(0, 5), 8'h80);
    do_read(ra(0, 5), d);
    total++; if (d !== 8'h80) begin bad++; $display("FAIL set_wins got=%h exp=80", d); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL set_wins_irq got=%b exp=1", irq); end
    do_write(ra(0, 5), 8'h80);
    tick();
    do_read(ra(0, 5), d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL fall_clear got=%h exp=00", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL fall_clear_irq got=%b exp=0", irq); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    do_write(ra(2, 4), 8'h01);
    pins_i[16] = 1'b0;
    repeat (4) tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
    power_on_reset_n = 1'b0;
    addr = ra(1, 0); dwrite = 8'h33; write_en = 1'b1;
    tick();
    write_en = 1'b0;
    power_on_reset_n = 1'b1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_reset_irq got=%b exp=0", irq); end
    total++; if (dread !== 8'h00) begin bad++; $display("FAIL mid_reset_dread got=%h exp=00", dread); end
    total++; if (pins_oe !== 24'h0) begin bad++; $display("FAIL mid_reset_oe got=%h exp=000000", pins_oe); end
    do_write(ra(2, 3), 8'hFF);
    do_write(ra(2, 4), 8'hFF);
    repeat (4) tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL resync_irq got=%b exp=0", irq); end
    do_read(ra(2, 5), d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL resync_flag got=%h exp=00", d); end
    do_read(ra(1, 0), d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL aborted_write got=%h exp=00", d); end
    pins_i[18] = 1'b0;
    repeat (4) tick();
    do_read(ra(2, 5), d);
    total++; if (d !== 8'h04) begin bad++; $display("FAIL post_window_edge got=%h exp=04", d); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    power_on_reset_n = 1'b0;
    addr = 5'd0;
    dwrite = 8'h00;
    write_en = 1'b0;
    read_en = 1'b0;
    pins_i = 24'h000000;
    test_reset();
    test_push_pull();
    test_open_drain();
    test_unmapped();
    test_rise_irq();
    test_set_clear_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 Parameter NPORTS, default 3, number of GPIO ports (1..8).
REQ-002 Parameter WIDTH, default 8, pins per port (1..8); unused data bits read 0 and ignore writes.
REQ-003 Parameter SYNC_STAGES, default 2, input synchroniser depth (2..3).
REQ-004 clk  input  1  system clock; one clock domain; reset is synchronous and active-low.
REQ-005 power_on_reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 addr  input  $clog2(NPORTS)+3  register address: port = addr[msb:3], register = addr[2:0].
REQ-007 dwrite  input  8  write data.
REQ-008 write_en  input  1  write strobe, one cycle per access.
REQ-009 read_en  input  1  read strobe, one cycle per access.
REQ-010 dread  output  8  registered read data.
REQ-011 pins_i  input  NPORTS*WIDTH  pad input values, asynchronous; port p at bits [p*WIDTH +: WIDTH].
REQ-012 pins_o  output  NPORTS*WIDTH  pad output values.
REQ-013 pins_oe  output  NPORTS*WIDTH  pad output enables; 1 = drive.
REQ-014 irq  output  1  level interrupt, OR of all enabled pending flags.

Function
REQ-015 Per-port register map: 0 ODR (output data, r/w); 1 DDR (direction, 1 = output, r/w); 2 IDR (synchronised input, read-only); 3 REN (rising-edge enable, r/w); 4 FEN (falling-edge enable, r/w); 5 IFR (pending flags, read, write-1-to-clear); 6 ODE (open-drain enable, r/w); 7 reserved (reads 0, writes ignored).
REQ-016 Addresses with port index >= NPORTS read 0; writes to them are ignored.
REQ-017 Writes take effect on the clk edge where write_en=1; pins_o and pins_oe reflect the new value in the following cycle.
REQ-018 Read latency is 1 cycle: dread is valid the cycle after read_en=1 and holds until the next read.
REQ-019 Push-pull pin (ODE=0): pins_o = ODR, pins_oe = DDR.
REQ-020 Open-drain pin (ODE=1): pins_o = 0, pins_oe = DDR & ~ODR.
REQ-021 pins_i passes through SYNC_STAGES flip-flops before any other use; IDR returns the last stage.
REQ-022 Edge detection compares the last sync stage with a 1-cycle-delayed copy of it. A 0->1 transition sets the IFR bit when REN=1. A 1->0 transition sets it when FEN=1.
REQ-023 Total delay from a pad edge to the IFR bit setting is SYNC_STAGES+1 clk cycles.
REQ-024 An IFR bit stays set until cleared by writing 1 to it; writing 0 has no effect.
REQ-025 If an edge sets an IFR bit in the same cycle that the bit is cleared, the set wins and the bit stays 1.
REQ-026 Edges are detected regardless of DDR, so output pins also flag their own transitions.
REQ-027 irq = OR over all ports of (IFR & (REN | FEN)), registered with 1 cycle latency.
REQ-028 If read_en and write_en assert together at the same address, the write completes and dread returns the pre-write value.

Reset
REQ-029 While power_on_reset_n=0 at a clk edge: ODR, DDR, REN, FEN, IFR and ODE clear to 0, and dread and irq clear to 0.
REQ-030 Reset also loads the synchroniser stages and the delayed copy with 0.
REQ-031 No edge flag may set during reset or in the first SYNC_STAGES+1 cycles after release.
REQ-032 After reset, pins_oe = 0 on all pins, so the block is tristated.
REQ-033 Reset asserted during a read or write aborts it; no register update occurs.

Structure
REQ-034 Package gpio_pkg holds the register offset constants (ODR..ODE) and the address-split helper widths.
REQ-035 One sub-module, gpio_sync (parametrised width and stages), performs synchronisation and rise/fall detection. It is instantiated once per port.
REQ-036 The block contains no latches and no combinational path from pins_i to any output.

Verification
REQ-037 Reset then read all registers of all ports -> all read 0 except IDR, which matches pins_i after 2 cycles; pins_oe = 0.
REQ-038 Write DDR[1]=0xFF, ODR[1]=0xA5 -> pins_o[15:8]=0xA5 and pins_oe[15:8]=0xFF one cycle after the write.
REQ-039 Write ODE[0]=0x0F, DDR[0]=0xFF, ODR[0]=0x05 -> pins_oe[3:0]=0xA and pins_o[3:0]=0.
REQ-040 Write REN[2]=0x01, then drive pins_i[16] 0->1 -> IFR[2]=0x01 exactly 3 cycles later and irq=1 one cycle after that. Write IFR[2]=0x01 -> irq=0.
REQ-041 Drive a falling edge with FEN=0x80 timed so the flag sets in the same cycle as a write of IFR=0x80 -> IFR stays 0x80.
REQ-042 Assert power_on_reset_n=0 for 1 cycle mid-sequence with IFR nonzero -> all state cleared and irq=0; no spurious flag during the resync window.
